// File: rtl/jelly_data_srl_fifo.sv
// ---------------------------------------------------------------------------
// jelly_data_srl_fifo
//
// Shallow elastic FIFO built from a shift-register chain. Every accepted
// write shifts the chain by one (new data enters entry 0). The read side
// selects the oldest entry through a variable tap at index cnt-1, so the
// storage maps onto SRL primitives instead of block RAM.
//
// Handshake (both sides): a transfer completes on a rising aclk edge where
// aclken=1 and valid=1 and ready=1. valid must not depend on ready. Once
// m_valid=1 the FIFO holds m_valid/m_data stable until m_ready=1.
//
// Optional feature macro: JELLY_DATA_SRL_FIFO_OUTPUT_REG_EN
//   undefined : m_data comes straight from the tap mux, 1-cycle latency,
//               capacity NUM.
//   defined   : a registered output stage follows the tap mux, 2-cycle
//               latency, capacity NUM+1.
//
// Ports
//   aclk        clock, rising edge
//   aresetn     asynchronous active-low reset
//   aclken      clock enable; low freezes every register
//   s_data      write payload          s_valid  write request
//   s_ready     write accept (registered)
//   m_data      oldest entry           m_valid  m_data valid (registered)
//   m_ready     reader accepts
//   data_count  entries held, output stage included
// ---------------------------------------------------------------------------
module jelly_data_srl_fifo #(
  parameter int PTR_WIDTH  = 4,
  parameter int NUM        = 1 << PTR_WIDTH,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PTR_WIDTH:0]    data_count
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] NUM_W = CW'(NUM);

  // Shift-register storage; intentionally not reset so it maps onto SRLs.
  logic [DATA_WIDTH-1:0] mem_q [NUM];

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  s_ready_q, s_ready_d;
  logic                  srl_push;
  logic                  srl_pop;
  logic [PTR_WIDTH-1:0]  tap_idx;
  logic [DATA_WIDTH-1:0] tap_data;

  assign srl_push = aclken & s_valid & s_ready_q;

  // Oldest entry lives at cnt-1; clamp to 0 when empty so the index never
  // wraps past the end of the array.
  assign tap_idx  = (cnt_q == '0) ? '0 : PTR_WIDTH'(cnt_q - CW'(1));
  assign tap_data = mem_q[tap_idx];

  always_ff @(posedge aclk) begin
    if (srl_push) begin
      mem_q[0] <= s_data;
      for (int k = 1; k < NUM; k++) begin
        mem_q[k] <= mem_q[k-1];
      end
    end
  end

  // On push+pop the shift itself moves the next-oldest entry into slot
  // cnt-1, so the count (and tap index) stays put.
  always_comb begin
    cnt_d = cnt_q;
    case ({srl_push, srl_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Ready looks at the next count, so a full FIFO refuses a write even
    // when a pop happens in the same cycle; ready returns one cycle later.
    s_ready_d = (cnt_d < NUM_W);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
    end else if (aclken) begin
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;

`ifdef JELLY_DATA_SRL_FIFO_OUTPUT_REG_EN
  // Registered output stage. Loading it from the tap is an internal pop of
  // the shift register.
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_load_en;

  assign out_load_en = aclken & (~out_valid_q | m_ready);
  assign srl_pop     = out_load_en & (cnt_q != '0);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_load_en) begin
      out_valid_d = (cnt_q != '0);
      if (cnt_q != '0) begin
        out_data_d = tap_data;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_valid    = out_valid_q;
  assign m_data     = out_data_q;
  assign data_count = cnt_q + CW'(out_valid_q);
`else
  logic m_valid_q, m_valid_d;

  assign srl_pop   = aclken & m_valid_q & m_ready;
  assign m_valid_d = (cnt_d != '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
    end else if (aclken) begin
      m_valid_q <= m_valid_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = tap_data;
  assign data_count = cnt_q;
`endif

endmodule

// File: tb/tb_jelly_data_srl_fifo.sv
// ---------------------------------------------------------------------------
// tb_jelly_data_srl_fifo
//
// Directed and random checks of jelly_data_srl_fifo with PTR_WIDTH=4,
// NUM=16, DATA_WIDTH=8. Inputs change 1 time unit after each rising edge;
// outputs are sampled at that same point, away from the edge.
// Expectations adapt to JELLY_DATA_SRL_FIFO_OUTPUT_REG_EN (latency and
// capacity).
// ---------------------------------------------------------------------------
module tb_jelly_data_srl_fifo;

  localparam int PTR_WIDTH  = 4;
  localparam int NUM        = 16;
  localparam int DATA_WIDTH = 8;
  localparam int DCW        = PTR_WIDTH + 1;
`ifdef JELLY_DATA_SRL_FIFO_OUTPUT_REG_EN
  localparam int LAT = 2;
  localparam int CAP = NUM + 1;
`else
  localparam int LAT = 1;
  localparam int CAP = NUM;
`endif
  localparam int PRINT_LIMIT = 50;

  // clock / reset
  logic aclk;
  logic aresetn;
  logic aclken;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [PTR_WIDTH:0]    data_count;

  int checks   = 0;
  int failures = 0;

  // scoreboard
  logic [DATA_WIDTH-1:0] exp_q[$];

  jelly_data_srl_fifo #(
    .PTR_WIDTH (PTR_WIDTH),
    .NUM       (NUM),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .aclken    (aclken),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .data_count(data_count)
  );

  // driver helper: advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    aclken  = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_ready !== 1'b0) begin
        failures++;
        if (failures <= PRINT_LIMIT) $display("FAIL reset_s_ready cyc=%0d got=%b exp=0", i, s_ready);
      end
      checks++;
      if (m_valid !== 1'b0 || data_count !== DCW'(0)) begin
        failures++;
        if (failures <= PRINT_LIMIT) $display("FAIL reset_empty cyc=%0d m_valid=%b data_count=%0d exp 0/0", i, m_valid, data_count);
      end
    end
    #2;
    aresetn = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL reset_release_pre got=%b exp=0", s_ready);
    end
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL reset_release_ready got=%b exp=1", s_ready);
    end
    checks++;
    if (m_valid !== 1'b0 || data_count !== DCW'(0)) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL reset_release_empty m_valid=%b data_count=%0d exp 0/0", m_valid, data_count);
    end
  endtask

  task automatic test_fill();
    m_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      s_valid = 1'b1;
      s_data  = DATA_WIDTH'(i);
      checks++;
      if (s_ready !== 1'b1) begin
        failures++;
        if (failures <= PRINT_LIMIT) $display("FAIL fill_ready idx=%0d got=%b exp=1", i, s_ready);
      end
      tick();
    end
    checks++;
    if (data_count !== DCW'(CAP)) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL fill_count got=%0d exp=%0d", data_count, CAP);
    end
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL fill_full_ready got=%b exp=0", s_ready);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h00) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL fill_head m_valid=%b m_data=%h exp 1/00", m_valid, m_data);
    end
    // extra write while full must be refused
    s_data = 8'hAA;
    tick();
    s_valid = 1'b0;
    checks++;
    if (data_count !== DCW'(CAP) || m_data !== 8'h00) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL fill_overflow data_count=%0d m_data=%h exp %0d/00", data_count, m_data, CAP);
    end
  endtask

  task automatic test_drain();
    m_ready = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== DATA_WIDTH'(i)) begin
        failures++;
        if (failures <= PRINT_LIMIT) $display("FAIL drain_data idx=%0d m_valid=%b m_data=%h exp 1/%h", i, m_valid, m_data, DATA_WIDTH'(i));
      end
      tick();
      if (i == 0) begin
        checks++;
        if (s_ready !== 1'b1) begin
          failures++;
          if (failures <= PRINT_LIMIT) $display("FAIL drain_ready_return got=%b exp=1", s_ready);
        end
      end
      checks++;
      if (data_count !== DCW'(CAP - 1 - i)) begin
        failures++;
        if (failures <= PRINT_LIMIT) $display("FAIL drain_count idx=%0d got=%0d exp=%0d", i, data_count, CAP - 1 - i);
      end
    end
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL drain_empty m_valid=%b exp=0", m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_streaming();
    int wr, rd, cyc;
    wr = 0;
    rd = 0;
    cyc = 0;
    m_ready = 1'b1;
    while (rd < 256 && cyc < 600) begin
      s_valid = (wr < 256);
      s_data  = DATA_WIDTH'(wr);
      if (m_valid) begin
        checks++;
        if (m_data !== DATA_WIDTH'(rd)) begin
          failures++;
          if (failures <= PRINT_LIMIT) $display("FAIL stream_data idx=%0d got=%h exp=%h", rd, m_data, DATA_WIDTH'(rd));
        end
        rd++;
      end
      if (cyc >= LAT && wr < 256) begin
        checks++;
        if (data_count !== DCW'(LAT)) begin
          failures++;
          if (failures <= PRINT_LIMIT) $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", cyc, data_count, LAT);
        end
      end
      if (s_valid && s_ready) wr++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    checks++;
    if (rd != 256) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL stream_timeout read=%0d exp=256", rd);
    end
    checks++;
    if (cyc != 256 + LAT) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL stream_throughput cycles=%0d exp=%0d", cyc, 256 + LAT);
    end
  endtask

  task automatic test_random();
    logic                  prev_stall;
    logic [DATA_WIDTH-1:0] prev_data;
    logic [DATA_WIDTH-1:0] exp;
    int                    cyc;
    prev_stall = 1'b0;
    prev_data  = '0;
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      s_valid = ($urandom_range(0, 99) < 50);
      s_data  = DATA_WIDTH'($urandom_range(0, 255));
      m_ready = ($urandom_range(0, 99) < 30);
      checks++;
      if (data_count !== DCW'(exp_q.size())) begin
        failures++;
        if (failures <= PRINT_LIMIT) $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, data_count, exp_q.size());
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          failures++;
          if (failures <= PRINT_LIMIT) $display("FAIL rand_stable cyc=%0d m_valid=%b m_data=%h exp 1/%h", c, m_valid, m_data, prev_data);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          if (failures <= PRINT_LIMIT) $display("FAIL rand_extra cyc=%0d got=%h exp=none", c, m_data);
        end else begin
          exp = exp_q.pop_front();
          if (m_data !== exp) begin
            failures++;
            if (failures <= PRINT_LIMIT) $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, m_data, exp);
          end
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
      tick();
    end
    // drain the remainder
    s_valid = 1'b0;
    m_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      if (m_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if (m_data !== exp) begin
          failures++;
          if (failures <= PRINT_LIMIT) $display("FAIL rand_drain got=%h exp=%h", m_data, exp);
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL rand_drain_end left=%0d m_valid=%b exp 0/0", exp_q.size(), m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_clken();
    int i, cyc;
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_data  = DATA_WIDTH'(8'h30 + k);
      tick();
    end
    s_valid = 1'b0;
    aclken  = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (data_count !== DCW'(5) || m_valid !== 1'b1 || m_data !== 8'h30 || s_ready !== 1'b1) begin
        failures++;
        if (failures <= PRINT_LIMIT) $display("FAIL clken_hold cyc=%0d count=%0d m_valid=%b m_data=%h s_ready=%b exp 5/1/30/1",
                                              k, data_count, m_valid, m_data, s_ready);
      end
    end
    s_valid = 1'b0;
    aclken  = 1'b1;
    i = 0;
    cyc = 0;
    while (i < 5 && cyc < 50) begin
      if (m_valid) begin
        checks++;
        if (m_data !== DATA_WIDTH'(8'h30 + i)) begin
          failures++;
          if (failures <= PRINT_LIMIT) $display("FAIL clken_data idx=%0d got=%h exp=%h", i, m_data, DATA_WIDTH'(8'h30 + i));
        end
        i++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (i != 5 || m_valid !== 1'b0 || data_count !== DCW'(0)) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL clken_end read=%0d m_valid=%b count=%0d exp 5/0/0", i, m_valid, data_count);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int i, cyc;
    m_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1;
      s_data  = DATA_WIDTH'(8'h50 + k);
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (data_count !== DCW'(7)) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL rmid_prefill got=%0d exp=7", data_count);
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (data_count !== DCW'(0) || m_valid !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL rmid_async count=%0d m_valid=%b s_ready=%b exp 0/0/0", data_count, m_valid, s_ready);
    end
    #2;
    aresetn = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL rmid_release s_ready=%b m_valid=%b exp 1/0", s_ready, m_valid);
    end
    s_valid = 1'b1;
    s_data  = 8'hC0;
    tick();
    s_data  = 8'hC1;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    i = 0;
    cyc = 0;
    while (cyc < 8) begin
      if (m_valid) begin
        checks++;
        if (i >= 2 || m_data !== DATA_WIDTH'(8'hC0 + i)) begin
          failures++;
          if (failures <= PRINT_LIMIT) $display("FAIL rmid_data idx=%0d got=%h exp=%h", i, m_data, DATA_WIDTH'(8'hC0 + i));
        end
        i++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (i != 2 || data_count !== DCW'(0)) begin
      failures++;
      if (failures <= PRINT_LIMIT) $display("FAIL rmid_end read=%0d count=%0d exp 2/0", i, data_count);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    aclken  = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_random();
    test_clken();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
